// File: rtl/axi_inter_wr_arb41.sv
// axi_inter_wr_arb41: round-robin 4-master AXI write arbiter, optional watchdog via AXI_ARB_TIMEOUT_EN
module axi_inter_wr_arb41 #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] m_awvalid,
  input  logic       s_awvalid,
  input  logic       s_awready,
  input  logic       s_wvalid,
  input  logic       s_wready,
  input  logic       s_wlast,
  input  logic       s_bvalid,
  input  logic       s_bready,
  output logic [1:0] sel,
  output logic       grant_valid,
  output logic [3:0] grant_onehot,
  output logic       timeout_err
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d, last_q, last_d, win;
  logic [3:0] oh_q, oh_d;
  logic aw_q, aw_d, w_q, w_d, gv_q, gv_d, te_q, te_d;
  logic aw_hs, w_hs, wl_hs, b_hs, to_hit;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs = s_wvalid & s_wready;
  assign wl_hs = w_hs & s_wlast;
  assign b_hs = s_bvalid & s_bready;
`ifdef AXI_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (state_q == IDLE || aw_hs || w_hs || b_hs) ? '0 : cnt_q + 1'b1;
    to_hit = state_q != IDLE && !(aw_hs || w_hs || b_hs) && cnt_d == TO_MAX;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYCLES > 0) && (TO_W > 0);
  assign to_hit = 1'b0;
`endif
  always_comb begin
    win = last_q;
    for (int i = 3; i >= 0; i--) begin
      logic [1:0] c;
      c = last_q + 2'(i + 1);
      if (m_awvalid[c]) win = c;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= 2'd0;
      last_q <= 2'd3;
      oh_q <= 4'd0;
      aw_q <= 1'b0;
      w_q <= 1'b0;
      gv_q <= 1'b0;
      te_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      oh_q <= oh_d;
      aw_q <= aw_d;
      w_q <= w_d;
      gv_q <= gv_d;
      te_q <= te_d;
    end
  end
  always_comb begin
    state_d = to_hit ? IDLE :
              state_q == IDLE ? (|m_awvalid ? XFER : IDLE) :
              state_q == XFER ? ((aw_d && w_d) ? RESP : XFER) :
              state_q == RESP ? (b_hs ? IDLE : RESP) : IDLE;
  end
  always_comb begin
    aw_d = state_q == XFER && (aw_q || aw_hs);
    w_d = state_q == XFER && (w_q || wl_hs);
    sel_d = (state_q == IDLE && |m_awvalid) ? win : sel_q;
    last_d = (state_q != IDLE && state_d == IDLE) ? sel_q : last_q;
    gv_d = state_d != IDLE;
    oh_d = gv_d ? 4'b0001 << sel_d : 4'b0000;
    te_d = to_hit;
  end
  assign sel = sel_q;
  assign grant_valid = gv_q;
  assign grant_onehot = oh_q;
  assign timeout_err = te_q;
endmodule

// File: tb/tb_axi_inter_wr_arb41.sv
// tb_axi_inter_wr_arb41: randomized and directed checks of the write arbiter against a transaction-level model
module tb_axi_inter_wr_arb41;
  localparam int TO = 16;
`ifdef AXI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] m_awvalid = 4'd0;
  logic s_awvalid = 1'b0, s_awready = 1'b0, s_wvalid = 1'b0, s_wready = 1'b0, s_wlast = 1'b0;
  logic s_bvalid = 1'b0, s_bready = 1'b0;
  logic [1:0] sel;
  logic grant_valid, timeout_err;
  logic [3:0] grant_onehot;
  int errs = 0, checks = 0;
  int m_ph = 0, m_sel = 0, m_last = 3, m_tc = 0;
  bit m_awd = 0, m_wd = 0, m_te = 0;
  axi_inter_wr_arb41 #(.TIMEOUT_CYCLES(TO), .TO_W(11)) dut (
    .clk(clk), .rst(rst), .m_awvalid(m_awvalid), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .sel(sel), .grant_valid(grant_valid), .grant_onehot(grant_onehot),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  function automatic int pick(int last, logic [3:0] r);
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction
  function automatic logic [3:0] exp_oh();
    return (m_ph != 0) ? 4'(1 << m_sel) : 4'd0;
  endfunction
  task automatic model_step();
    bit aw, w, wl, b;
    aw = s_awvalid && s_awready;
    w = s_wvalid && s_wready;
    wl = w && s_wlast;
    b = s_bvalid && s_bready;
    m_te = 0;
    if (rst) begin
      m_ph = 0; m_sel = 0; m_last = 3; m_awd = 0; m_wd = 0; m_tc = 0;
    end else if (m_ph == 0) begin
      if (m_awvalid != 0) begin
        m_sel = pick(m_last, m_awvalid); m_ph = 1; m_awd = 0; m_wd = 0; m_tc = 0;
      end
    end else begin
      m_tc = (aw || w || b) ? 0 : m_tc + 1;
      if (TO_EN && m_tc == TO) begin
        m_ph = 0; m_last = m_sel; m_te = 1; m_tc = 0;
      end else if (m_ph == 1) begin
        m_awd = m_awd || aw;
        m_wd = m_wd || wl;
        if (m_awd && m_wd) m_ph = 2;
      end else if (b) begin
        m_ph = 0; m_last = m_sel;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic clear_slave();
    {s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready} = 7'd0;
  endtask
  task automatic do_reset();
    rst = 1'b1; m_awvalid = 4'd0; clear_slave();
    tick(); tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (sel !== 2'd0 || grant_valid !== 1'b0 || grant_onehot !== 4'd0 || timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL reset: sel=%0d gv=%b oh=%b te=%b, want 0/0/0000/0", sel, grant_valid, grant_onehot, timeout_err);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b0 || sel !== 2'd0) begin
      errs++;
      $display("FAIL idle_no_req: sel=%0d gv=%b, want 0/0", sel, grant_valid);
    end
  endtask
  task automatic test_first_grant();
    do_reset();
    m_awvalid = 4'b1010;
    tick();
    checks++;
    if (sel !== 2'd1 || grant_valid !== 1'b1 || grant_onehot !== 4'b0010) begin
      errs++;
      $display("FAIL first_grant: sel=%0d gv=%b oh=%b, want 1/1/0010", sel, grant_valid, grant_onehot);
    end
  endtask
  task automatic test_rotation();
    do_reset();
    m_awvalid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if (grant_valid !== 1'b1 || sel !== 2'(g % 4) || grant_onehot !== 4'(1 << (g % 4))) begin
        errs++;
        $display("FAIL rotation[%0d]: sel=%0d gv=%b oh=%b, want %0d/1", g, sel, grant_valid, grant_onehot, g % 4);
      end
      {s_awvalid, s_awready, s_wvalid, s_wready, s_wlast} = 5'b11111;
      tick();
      clear_slave();
      {s_bvalid, s_bready} = 2'b11;
      tick();
      clear_slave();
      checks++;
      if (grant_valid !== 1'b0 || grant_onehot !== 4'd0) begin
        errs++;
        $display("FAIL rotation_gap[%0d]: gv=%b oh=%b, want 0/0000", g, grant_valid, grant_onehot);
      end
    end
  endtask
  task automatic test_w_before_aw();
    do_reset();
    m_awvalid = 4'b0100;
    tick();
    m_awvalid = 4'b1000;
    {s_wvalid, s_wready, s_wlast} = 3'b111;
    tick();
    clear_slave();
    tick();
    {s_bvalid, s_bready} = 2'b11;
    tick();
    clear_slave();
    checks++;
    if (grant_valid !== 1'b1 || sel !== 2'd2 || m_ph != 1) begin
      errs++;
      $display("FAIL w_first_hold: sel=%0d gv=%b, want 2/1 in xfer", sel, grant_valid);
    end
    {s_awvalid, s_awready} = 2'b11;
    tick();
    clear_slave();
    {s_bvalid, s_bready} = 2'b11;
    tick();
    clear_slave();
    checks++;
    if (grant_valid !== 1'b0 || m_ph != 0) begin
      errs++;
      $display("FAIL w_first_release: gv=%b, want 0", grant_valid);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || sel !== 2'd3 || grant_onehot !== 4'b1000) begin
      errs++;
      $display("FAIL w_first_next: sel=%0d gv=%b oh=%b, want 3/1/1000", sel, grant_valid, grant_onehot);
    end
  endtask
  task automatic test_same_cycle();
    do_reset();
    m_awvalid = 4'b0001;
    tick();
    m_awvalid = 4'b0000;
    {s_bvalid, s_bready} = 2'b11;
    tick();
    clear_slave();
    {s_awvalid, s_awready, s_wvalid, s_wready, s_wlast} = 5'b11111;
    tick();
    clear_slave();
    tick();
    checks++;
    if (grant_valid !== 1'b1 || sel !== 2'd0 || m_ph != 2) begin
      errs++;
      $display("FAIL same_cycle_resp: sel=%0d gv=%b, want 0/1 in resp", sel, grant_valid);
    end
    {s_bvalid, s_bready} = 2'b11;
    tick();
    clear_slave();
    checks++;
    if (grant_valid !== 1'b0 || grant_onehot !== 4'd0) begin
      errs++;
      $display("FAIL same_cycle_done: gv=%b oh=%b, want 0/0000", grant_valid, grant_onehot);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    m_awvalid = 4'b0100;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || sel !== 2'd0 || grant_onehot !== 4'd0) begin
      errs++;
      $display("FAIL reset_mid: sel=%0d gv=%b oh=%b, want 0/0/0000", sel, grant_valid, grant_onehot);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || sel !== 2'd2 || grant_onehot !== 4'b0100) begin
      errs++;
      $display("FAIL reset_regrant: sel=%0d gv=%b oh=%b, want 2/1/0100", sel, grant_valid, grant_onehot);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    m_awvalid = 4'b0001;
    tick();
    m_awvalid = 4'b0010;
    for (int c = 1; c <= TO + 1; c++) begin
      tick();
      checks++;
      if (sel !== 2'(m_sel) || grant_valid !== (m_ph != 0) || grant_onehot !== exp_oh() || timeout_err !== m_te) begin
        errs++;
        $display("FAIL timeout[%0d]: sel=%0d gv=%b oh=%b te=%b, want %0d/%b/%b/%b",
                 c, sel, grant_valid, grant_onehot, timeout_err, m_sel, m_ph != 0, exp_oh(), m_te);
      end
    end
    checks++;
    if (TO_EN ? (sel !== 2'd1 || grant_valid !== 1'b1) : (sel !== 2'd0 || grant_valid !== 1'b1)) begin
      errs++;
      $display("FAIL timeout_final: sel=%0d gv=%b, want %0d/1", sel, grant_valid, TO_EN ? 1 : 0);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      m_awvalid = 4'($urandom_range(0, 15));
      s_awvalid = ($urandom_range(0, 3) == 0);
      s_awready = $urandom_range(0, 1) == 1;
      s_wvalid = ($urandom_range(0, 2) == 0);
      s_wready = $urandom_range(0, 1) == 1;
      s_wlast = $urandom_range(0, 1) == 1;
      s_bvalid = ($urandom_range(0, 2) == 0);
      s_bready = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 40) == 0) {s_awvalid, s_wvalid, s_bvalid} = 3'd0;
      tick();
      checks++;
      if (sel !== 2'(m_sel) || grant_valid !== (m_ph != 0) || grant_onehot !== exp_oh() || timeout_err !== m_te) begin
        errs++;
        $display("FAIL random[%0d]: sel=%0d gv=%b oh=%b te=%b, want %0d/%b/%b/%b",
                 c, sel, grant_valid, grant_onehot, timeout_err, m_sel, m_ph != 0, exp_oh(), m_te);
      end
    end
    rst = 1'b0;
    clear_slave();
  endtask
  initial begin
    test_reset();
    test_first_grant();
    test_rotation();
    test_w_before_aw();
    test_same_cycle();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
